// File: rtl/coherence_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : coherence_bus_arbiter
// Purpose  : Registered one-hot arbiter for the shared coherence bus slot,
//            round-robin or fixed priority with aging starvation escape.
// Revision : 1.0
// ============================================================================
module coherence_bus_arbiter #(
  parameter int NREQ    = 4,
  parameter int MODE    = 0,
  parameter int AGE_MAX = 15,
  parameter int IDXW    = $clog2(NREQ)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [NREQ-1:0] req,
  input  logic            done,
  input  logic            abort,
  output logic [NREQ-1:0] grant,
  output logic            grant_valid,
  output logic [IDXW-1:0] grant_idx,
  output logic [NREQ-1:0] starve
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [IDXW-1:0] idx_q,   idx_d;
  logic [IDXW-1:0] ptr_q,   ptr_d;

  logic [IDXW-1:0] w_win_idx;
  logic [IDXW-1:0] w_low_idx;
  logic [IDXW-1:0] w_hit_idx;
  logic            w_hit;
  logic            w_take;
  int              w_rot;

  // Winner selection; only meaningful when some req bit is set.
  always_comb begin
    w_win_idx = '0;
    w_low_idx = '0;
    w_hit_idx = '0;
    w_hit     = 1'b0;
    w_rot     = 0;
    if (MODE == 0) begin
      for (int k = NREQ-1; k >= 0; k--) begin
        w_rot = int'(ptr_q) + k;
        if (w_rot >= NREQ) w_rot = w_rot - NREQ;
        if (req[IDXW'(w_rot)]) w_win_idx = IDXW'(w_rot);
      end
    end else begin
      for (int i = NREQ-1; i >= 0; i--) begin
        if (req[i]) w_low_idx = IDXW'(i);
        if (req[i] && starve[i]) begin
          w_hit     = 1'b1;
          w_hit_idx = IDXW'(i);
        end
      end
      w_win_idx = w_hit ? w_hit_idx : w_low_idx;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    w_take  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          state_d = S_BUSY;
          grant_d = {{(NREQ-1){1'b0}}, 1'b1} << w_win_idx;
          idx_d   = w_win_idx;
          w_take  = 1'b1;
        end
      end
      S_BUSY: begin
        // abort wins over done so the owner keeps its turn
        if (abort) begin
          state_d = S_IDLE;
          grant_d = '0;
        end else if (done) begin
          state_d = S_IDLE;
          grant_d = '0;
          ptr_d   = (idx_q == IDXW'(NREQ-1)) ? '0 : idx_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
    end
  end

  generate
    if (MODE == 1) begin : g_age
      localparam int AGEW = $clog2(AGE_MAX + 1);
      for (genvar i = 0; i < NREQ; i++) begin : g_cnt
        logic [AGEW-1:0] age_q, age_d;

        always_comb begin
          age_d = age_q;
          if (!req[i] || (w_take && (w_win_idx == IDXW'(i)))) begin
            age_d = '0;
          end else if (!grant_q[i] && (age_q != AGEW'(AGE_MAX))) begin
            age_d = age_q + 1'b1;
          end
        end

        always_ff @(posedge CLK) begin
          if (RST) age_q <= '0;
          else     age_q <= age_d;
        end

        assign starve[i] = (age_q == AGEW'(AGE_MAX));
      end
    end else begin : g_no_age
      assign starve = '0;
    end
  endgenerate

  assign grant       = grant_q;
  assign grant_valid = (state_q == S_BUSY);
  assign grant_idx   = idx_q;

endmodule
`default_nettype wire

// File: tb/tb_coherence_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_coherence_bus_arbiter
// Purpose  : Bench driving a round-robin and an aging instance side by side,
//            checked against directed expectations and a behavioural model.
// Revision : 1.0
// ============================================================================
module tb_coherence_bus_arbiter;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [3:0] req = 4'b0;
  logic       done = 1'b0;
  logic       abort = 1'b0;

  logic [3:0] g0, g1, st0, st1;
  logic       gv0, gv1;
  logic [1:0] gi0, gi1;

  int n_tests = 0;
  int n_fail  = 0;

  // model state: [0] = round-robin instance, [1] = aging instance
  int m_busy [2];
  int m_own  [2];
  int m_idx  [2];
  int m_ptr;
  int m_age  [4];

  always #5 CLK = ~CLK;

  coherence_bus_arbiter #(.NREQ(4), .MODE(0)) dut0 (
    .CLK(CLK), .RST(RST), .req(req), .done(done), .abort(abort),
    .grant(g0), .grant_valid(gv0), .grant_idx(gi0), .starve(st0)
  );

  coherence_bus_arbiter #(.NREQ(4), .MODE(1), .AGE_MAX(3)) dut1 (
    .CLK(CLK), .RST(RST), .req(req), .done(done), .abort(abort),
    .grant(g1), .grant_valid(gv1), .grant_idx(gi1), .starve(st1)
  );

  function automatic logic [3:0] exp_grant(int m);
    return m_busy[m] != 0 ? 4'(1 << m_own[m]) : 4'b0000;
  endfunction

  function automatic logic [3:0] exp_starve();
    logic [3:0] s;
    for (int i = 0; i < 4; i++) s[i] = (m_age[i] == 3);
    return s;
  endfunction

  task automatic model_step();
    int w;
    int s;
    if (RST) begin
      for (int m = 0; m < 2; m++) begin
        m_busy[m] = 0; m_own[m] = 0; m_idx[m] = 0;
      end
      m_ptr = 0;
      for (int i = 0; i < 4; i++) m_age[i] = 0;
      return;
    end
    // round-robin: first requester at or after the pointer, wrapping
    if (m_busy[0] == 0) begin
      if (req != 0) begin
        w = -1;
        for (int k = 0; k < 4 && w < 0; k++)
          if (req[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
        m_busy[0] = 1; m_own[0] = w; m_idx[0] = w;
      end
    end else if (abort) begin
      m_busy[0] = 0;
    end else if (done) begin
      m_busy[0] = 0;
      m_ptr = (m_own[0] + 1) % 4;
    end
    // fixed priority with starvation escape
    w = -1;
    if (m_busy[1] == 0 && req != 0) begin
      s = -1;
      for (int i = 0; i < 4; i++) begin
        if (req[i] && w < 0) w = i;
        if (req[i] && m_age[i] == 3 && s < 0) s = i;
      end
      if (s >= 0) w = s;
    end
    for (int i = 0; i < 4; i++) begin
      if (!req[i] || i == w) m_age[i] = 0;
      else if (!(m_busy[1] != 0 && m_own[1] == i) && m_age[i] < 3) m_age[i]++;
    end
    if (m_busy[1] == 0) begin
      if (w >= 0) begin
        m_busy[1] = 1; m_own[1] = w; m_idx[1] = w;
      end
    end else if (abort || done) begin
      m_busy[1] = 0;
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1; req = 4'b0; done = 1'b0; abort = 1'b0;
    tick(); tick();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; req = 4'b1111; done = 1'b0; abort = 1'b0;
    tick(); tick();
    n_tests++;
    if (g0 !== 4'b0 || gv0 !== 1'b0 || gi0 !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_rr: grant=%b valid=%b idx=%0d required 0000/0/0", g0, gv0, gi0);
    end
    n_tests++;
    if (g1 !== 4'b0 || gv1 !== 1'b0 || st1 !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_age: grant=%b valid=%b starve=%b required 0000/0/0000", g1, gv1, st1);
    end
    RST = 1'b0;
    tick();
    n_tests++;
    if (g0 !== 4'b0001 || gv0 !== 1'b1 || gi0 !== 2'd0) begin
      n_fail++;
      $display("FAIL first_grant: grant=%b valid=%b idx=%0d required 0001/1/0", g0, gv0, gi0);
    end
  endtask

  task automatic test_rr_rotation();
    logic [3:0] exp;
    do_reset();
    req = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      exp = 4'(1 << (k % 4));
      n_tests++;
      if (g0 !== exp) begin
        n_fail++;
        $display("FAIL rr_grant_%0d: grant=%b required %b", k, g0, exp);
      end
      tick();
      done = 1'b1;
      tick();
      done = 1'b0;
      n_tests++;
      if (g0 !== 4'b0 || gv0 !== 1'b0) begin
        n_fail++;
        $display("FAIL rr_bubble_%0d: grant=%b valid=%b required 0000/0", k, g0, gv0);
      end
      tick();
    end
  endtask

  task automatic test_abort();
    do_reset();
    req = 4'b1111;
    tick();
    for (int k = 0; k < 2; k++) begin
      done = 1'b1; tick(); done = 1'b0; tick();
    end
    n_tests++;
    if (g0 !== 4'b0100) begin
      n_fail++;
      $display("FAIL abort_setup: grant=%b required 0100", g0);
    end
    abort = 1'b1; tick(); abort = 1'b0;
    n_tests++;
    if (g0 !== 4'b0) begin
      n_fail++;
      $display("FAIL abort_release: grant=%b required 0000", g0);
    end
    tick();
    n_tests++;
    if (g0 !== 4'b0100 || gi0 !== 2'd2) begin
      n_fail++;
      $display("FAIL abort_regrant: grant=%b idx=%0d required 0100/2", g0, gi0);
    end
    done = 1'b1; abort = 1'b1; tick(); done = 1'b0; abort = 1'b0;
    tick();
    n_tests++;
    if (g0 !== 4'b0100) begin
      n_fail++;
      $display("FAIL done_abort_regrant: grant=%b required 0100", g0);
    end
    done = 1'b1; tick(); done = 1'b0; tick();
    n_tests++;
    if (g0 !== 4'b1000) begin
      n_fail++;
      $display("FAIL after_abort_done: grant=%b required 1000", g0);
    end
  endtask

  task automatic test_grant_hold();
    do_reset();
    req = 4'b0010;
    tick();
    req = 4'b0001;
    tick(); tick(); tick();
    n_tests++;
    if (g0 !== 4'b0010 || gv0 !== 1'b1) begin
      n_fail++;
      $display("FAIL hold: grant=%b valid=%b required 0010/1", g0, gv0);
    end
    done = 1'b1; tick(); done = 1'b0;
    n_tests++;
    if (g0 !== 4'b0) begin
      n_fail++;
      $display("FAIL hold_release: grant=%b required 0000", g0);
    end
    tick();
    n_tests++;
    if (g0 !== 4'b0001) begin
      n_fail++;
      $display("FAIL hold_next: grant=%b required 0001", g0);
    end
  endtask

  task automatic test_aging();
    do_reset();
    req = 4'b0011;
    tick();
    n_tests++;
    if (g1 !== 4'b0001 || st1 !== 4'b0) begin
      n_fail++;
      $display("FAIL age_first: grant=%b starve=%b required 0001/0000", g1, st1);
    end
    done = 1'b1; tick(); done = 1'b0; tick();
    n_tests++;
    if (g1 !== 4'b0001 || st1 !== 4'b0010) begin
      n_fail++;
      $display("FAIL age_passed_over: grant=%b starve=%b required 0001/0010", g1, st1);
    end
    done = 1'b1; tick(); done = 1'b0; tick();
    n_tests++;
    if (g1 !== 4'b0010 || gi1 !== 2'd1 || st1 !== 4'b0) begin
      n_fail++;
      $display("FAIL age_escape: grant=%b idx=%0d starve=%b required 0010/1/0000", g1, gi1, st1);
    end
  endtask

  task automatic test_stray();
    do_reset();
    req = 4'b0010;
    tick();
    req = 4'b0;
    done = 1'b1; tick(); done = 1'b0;
    tick();
    done = 1'b1; tick(); done = 1'b0;
    abort = 1'b1; tick(); abort = 1'b0;
    tick();
    n_tests++;
    if (g0 !== 4'b0 || gv0 !== 1'b0 || gi0 !== 2'd1) begin
      n_fail++;
      $display("FAIL stray_idle: grant=%b valid=%b idx=%0d required 0000/0/1", g0, gv0, gi0);
    end
    req = 4'b0100;
    tick();
    n_tests++;
    if (g0 !== 4'b0100 || gi0 !== 2'd2) begin
      n_fail++;
      $display("FAIL stray_next: grant=%b idx=%0d required 0100/2", g0, gi0);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    req = 4'b0011;
    tick();
    done = 1'b1; tick();
    tick();
    done = 1'b0;
    tick();
    n_tests++;
    if (g0 !== 4'b0010 || gv0 !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_done: grant=%b valid=%b required 0010/1", g0, gv0);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      req   = ($urandom_range(0, 3) == 0) ? 4'b0 : 4'($urandom);
      done  = ($urandom_range(0, 2) == 0);
      abort = ($urandom_range(0, 6) == 0);
      RST   = ($urandom_range(0, 199) == 0);
      tick();
      n_tests++;
      if (g0 !== exp_grant(0) || gv0 !== (m_busy[0] != 0) || gi0 !== 2'(m_idx[0]) || st0 !== 4'b0) begin
        n_fail++;
        $display("FAIL rand_rr cyc %0d: grant=%b valid=%b idx=%0d starve=%b required %b/%0d/%0d/0000",
                 c, g0, gv0, gi0, st0, exp_grant(0), m_busy[0], m_idx[0]);
      end
      n_tests++;
      if (g1 !== exp_grant(1) || gv1 !== (m_busy[1] != 0) || gi1 !== 2'(m_idx[1]) || st1 !== exp_starve()) begin
        n_fail++;
        $display("FAIL rand_age cyc %0d: grant=%b valid=%b idx=%0d starve=%b required %b/%0d/%0d/%b",
                 c, g1, gv1, gi1, st1, exp_grant(1), m_busy[1], m_idx[1], exp_starve());
      end
    end
    RST = 1'b0; done = 1'b0; abort = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rr_rotation();
    test_abort();
    test_grant_hold();
    test_aging();
    test_stray();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
